// File: rtl/boa_pmu_ctrl_if.sv
// Request/status bundle between the core's pmu_bus and boa_pmu_ctrl.
// master = core side (issues requests), slave = PMU side (drives reset/shutdown/cause).
interface boa_pmu_ctrl_if;
    logic       sw_rst;
    logic       sw_shdn;
    logic       ext_wake;
    logic       cause_clr;
    logic       wdt_kick;
    logic       sys_rst;
    logic       shdn;
    logic [3:0] rst_cause;

    modport master (
        output sw_rst, sw_shdn, ext_wake, cause_clr, wdt_kick,
        input  sys_rst, shdn, rst_cause
    );

    modport slave (
        input  sw_rst, sw_shdn, ext_wake, cause_clr, wdt_kick,
        output sys_rst, shdn, rst_cause
    );
endinterface

// File: rtl/boa_pmu_ctrl.sv
// Button debounce, reset stretching, shutdown/wake FSM and sticky reset-cause record.
// Optional watchdog is compiled in when PMU_WATCHDOG_EN is defined.
module boa_pmu_ctrl #(
    parameter int unsigned            btn_count       = 5,
    parameter int unsigned            debounce_cycles = 100000,
    parameter int unsigned            rst_hold        = 16,
    parameter logic [btn_count-1:0]   rst_btn_mask    = 'b1,
    parameter logic [btn_count-1:0]   wake_btn_mask   = '1,
    parameter int unsigned            wdt_cycles      = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [btn_count-1:0] btn_in,
    output logic [btn_count-1:0] btn_db,
    output logic [btn_count-1:0] btn_rise,
    boa_pmu_ctrl_if.slave        pmu
);

    localparam int unsigned    DbW     = $clog2(debounce_cycles);
    localparam int unsigned    HoldW   = (rst_hold > 1) ? $clog2(rst_hold) : 1;
    localparam logic [DbW-1:0] DbMax   = DbW'(debounce_cycles - 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(rst_hold - 1);

    typedef enum logic [1:0] {StHold, StRun, StShdn} state_e;

    state_e               state_q, state_d;
    logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [btn_count-1:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic [btn_count-1:0] btn_db_q, btn_db_d, btn_rise_q, btn_rise_d;
    logic [DbW-1:0]       db_cnt_q [btn_count];
    logic [DbW-1:0]       db_cnt_d [btn_count];
    logic [3:0]           cause_q, cause_d;
    logic                 wdt_expire;
    logic                 rsrc;
    logic                 wake;

    always_comb begin
        btn_s1_d   = btn_in;
        btn_s2_d   = btn_s1_q;
        btn_db_d   = btn_db_q;
        btn_rise_d = '0;
        for (int i = 0; i < btn_count; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (btn_s2_q[i] == btn_db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DbMax) begin
                btn_db_d[i]   = ~btn_db_q[i];
                btn_rise_d[i] = ~btn_db_q[i];
                db_cnt_d[i]   = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

`ifdef PMU_WATCHDOG_EN
    localparam int unsigned      WdtW   = (wdt_cycles > 1) ? $clog2(wdt_cycles) : 1;
    localparam logic [WdtW-1:0]  WdtMax = WdtW'(wdt_cycles - 1);

    logic [WdtW-1:0] wdt_cnt_q, wdt_cnt_d;

    // A kick in the terminal cycle still counts as a refresh.
    always_comb begin
        wdt_expire = 1'b0;
        wdt_cnt_d  = wdt_cnt_q;
        if (state_q != StRun || pmu.wdt_kick) begin
            wdt_cnt_d = '0;
        end else if (wdt_cnt_q == WdtMax) begin
            wdt_expire = 1'b1;
            wdt_cnt_d  = '0;
        end else begin
            wdt_cnt_d = wdt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) wdt_cnt_q <= '0;
        else        wdt_cnt_q <= wdt_cnt_d;
    end
`else
    localparam int unsigned unused_wdt_cycles = wdt_cycles;
    logic unused_wdt_kick;
    assign unused_wdt_kick = pmu.wdt_kick;
    assign wdt_expire      = 1'b0;
`endif

    assign rsrc = (|(btn_db_q & rst_btn_mask)) | pmu.sw_rst | wdt_expire;
    assign wake = pmu.ext_wake | (|(btn_rise_q & wake_btn_mask));

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        unique case (state_q)
            StHold: begin
                if (rsrc) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HoldMax) begin
                    state_d = StRun;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (rsrc)             state_d = StHold;
                else if (pmu.sw_shdn) state_d = StShdn;
            end
            StShdn: begin
                // Wake always passes through a full reset hold.
                if (rsrc || wake) state_d = StHold;
            end
            default: state_d = StHold;
        endcase
    end

    always_comb begin
        cause_d = (pmu.cause_clr ? 4'b0000 : cause_q)
                | {wdt_expire, pmu.sw_rst, |(btn_db_q & rst_btn_mask), 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StHold;
            hold_cnt_q <= '0;
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            btn_db_q   <= '0;
            btn_rise_q <= '0;
            cause_q    <= 4'b0001;
            for (int i = 0; i < btn_count; i++) db_cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            btn_s1_q   <= btn_s1_d;
            btn_s2_q   <= btn_s2_d;
            btn_db_q   <= btn_db_d;
            btn_rise_q <= btn_rise_d;
            cause_q    <= cause_d;
            for (int i = 0; i < btn_count; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    assign pmu.sys_rst   = (state_q == StHold);
    assign pmu.shdn      = (state_q == StShdn);
    assign pmu.rst_cause = cause_q;
    assign btn_db        = btn_db_q;
    assign btn_rise      = btn_rise_q;

endmodule

// File: doc/boa_pmu_ctrl.md
Name: boa_pmu_ctrl

Overview:
Power-management and reset controller for FPGA top levels. It synchronises and debounces a parametrised number of board buttons, merges button, software and external wake/reset requests, and generates a stretched system reset and a shutdown (clock-gate) signal. It also records a sticky reset-cause vector. It sits between the board pins and the core's `pmu_bus` request lines, replacing ad-hoc per-board reset/shutdown logic.

Parameters:
btn_count, 5, number of button inputs (1..16)
debounce_cycles, 100000, stable cycles required before a debounced button changes state (≥2)
rst_hold, 16, minimum cycles `sys_rst` stays high after the last reset source clears (≥1)
rst_btn_mask, 'b1, buttons whose debounced high level forces reset
wake_btn_mask, '1, buttons whose debounced rising edge wakes from shutdown
wdt_cycles, 1000000, watchdog timeout in cycles (used only with PMU_WATCHDOG_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  power-on reset, synchronous, active-low
btn_in  in  btn_count  raw asynchronous button levels
sw_rst  in  1  software reset request (level)
sw_shdn  in  1  software shutdown request (level)
ext_wake  in  1  external wake request, already synchronous to clk
cause_clr  in  1  one-cycle pulse that clears `rst_cause`
wdt_kick  in  1  watchdog refresh pulse (ignored when the watchdog is compiled out)
sys_rst  out  1  system reset to core and peripherals, active-high
shdn  out  1  shutdown; the top ORs it into the core clock
btn_db  out  btn_count  debounced button levels
btn_rise  out  btn_count  one-cycle pulse on each debounced rising edge
rst_cause  out  4  sticky cause: [0] power-on, [1] button, [2] software, [3] watchdog

Behaviour:
- Reset (`rst_n`=0 at a clk edge): state HOLD; `sys_rst`=1; `shdn`=0; hold counter=0; `btn_db`=0; `btn_rise`=0; `rst_cause`=4'b0001; synchronisers and debounce counters=0; watchdog counter=0.
- Input path: 2-flop synchroniser per button, then a per-channel debounce counter.
  - The counter increments while the synchronised level ≠ `btn_db`, and clears when they are equal.
  - When it reaches `debounce_cycles`-1, `btn_db` toggles and the counter clears.
  - `btn_rise` is high for exactly the cycle after `btn_db` goes 0→1.
  - Raw-pin-to-`btn_db` latency is 2 + `debounce_cycles` cycles.
- Reset source `rsrc` = (|(`btn_db` & `rst_btn_mask`)) | `sw_rst` | wdt_expire.
- FSM:
  - HOLD: `sys_rst`=1, `shdn`=0. The counter clears whenever `rsrc` is high; otherwise it increments. When it reaches `rst_hold`-1 with `rsrc` low, go to RUN. Minimum HOLD length is `rst_hold` cycles.
  - RUN: `sys_rst`=0. If `rsrc` → HOLD. Else if `sw_shdn` → SHDN.
  - SHDN: `shdn`=1, `sys_rst`=0. If `rsrc` → HOLD. Else if `ext_wake` or |(`btn_rise` & `wake_btn_mask`) → HOLD (wake goes through a full reset). Leaving SHDN clears `shdn` on the same edge.
  - Simultaneous `rsrc` and `sw_shdn` in RUN: reset wins.
  - `sw_shdn` held high in HOLD is ignored until RUN is reached.
- Outputs `sys_rst` and `shdn` are registered (decoded from the state register); there are no combinational paths from inputs.
- `rst_cause`:
  - Set bits OR in on every cycle the corresponding source is active: bit1 from the masked `btn_db`, bit2 from `sw_rst`, bit3 from wdt_expire.
  - Bit0 is set only by `rst_n`.
  - If `cause_clr` and a set occur in the same cycle, the set bit survives and the others clear.
- The hold and debounce counters are sized by $clog2 of their limits; they saturate and never wrap.

Optional Feature:
PMU_WATCHDOG_EN
- Defined:
  - A watchdog counter runs only in RUN and is cleared by `wdt_kick` or on leaving RUN.
  - On reaching `wdt_cycles`-1 it asserts wdt_expire for one cycle, which forces HOLD and sets `rst_cause`[3].
- Undefined:
  - No watchdog logic; wdt_expire is constant 0.
  - `wdt_kick` is unused.
  - `rst_cause`[3] reads 0.

Test Plan (btn_count=2, debounce_cycles=4, rst_hold=3, rst_btn_mask=2'b01, wake_btn_mask=2'b10, wdt_cycles=20):
- Power-on: `rst_n`=0 for 2 cycles, then 1 → `sys_rst` high for exactly 3 cycles after release, then 0; `rst_cause`=4'b0001; `shdn`=0.
- Bounce: `btn_in`[0] toggles every 2 cycles for 10 cycles, then holds 1 → `btn_db`[0] stays 0 during the bouncing; it rises 6 cycles after the final edge; `btn_rise`[0] pulses once; `sys_rst` goes high the next cycle and stays high until 3 cycles after `btn_db`[0] falls; `rst_cause`[1]=1.
- Shutdown/wake: in RUN, pulse `sw_shdn` → `shdn`=1 next cycle. Pressing `btn_in`[0]-style noise on channel 1 for less than 4 cycles leaves state unchanged. A clean 10-cycle press on channel 1 → `btn_rise`[1] fires, `shdn`→0, `sys_rst` high for 3 cycles.
- Priority: `sw_rst` and `sw_shdn` high in the same RUN cycle → HOLD, `shdn` stays 0, `rst_cause`[2]=1.
- Cause clear: `cause_clr` pulse while `sw_rst`=0 → `rst_cause`=0. `cause_clr` in the same cycle as `sw_rst`=1 → `rst_cause`=4'b0100.
- With PMU_WATCHDOG_EN: in RUN with no `wdt_kick` for 20 cycles → `sys_rst` rises at cycle 20 and `rst_cause`[3]=1. Kicking every 15 cycles → no reset over 200 cycles. Without the macro: no reset over 200 cycles.
